array_mac_streamer: RTL

ARRAY_MAC_STREAMER -- requirements
Module: array_mac_streamer

---
 rtl/array_mac_streamer_if.sv | 32 +++
 rtl/array_mac_streamer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/array_mac_streamer_if.sv
// Result stream handshake for array_mac_streamer.
// The streamer drives the master side; the consumer sits on the slave side.
interface array_mac_streamer_if #(
    parameter int ROW   = 2,
    parameter int COL   = 2,
    parameter int WIDTH = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [ROW-1:0]   out_row;
    logic [COL-1:0]   out_col;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_col,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_col,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/array_mac_streamer.sv
// Streams the element-wise products array1[i][j] * array2[j][i] in row-major
// order over a valid/ready channel, keeping a running total of what was sent.
// Both arrays are snapshotted when a pass starts, so the inputs may change freely
// during the pass.
module array_mac_streamer #(
    parameter int ROW   = 2,
    parameter int COL   = 2,
    parameter int WIDTH = 8,
    localparam int ROW_SIZE = 2**ROW,
    localparam int COL_SIZE = 2**COL,
    localparam int NUM      = ROW_SIZE * COL_SIZE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [NUM*WIDTH-1:0]       array1,
    input  logic [NUM*WIDTH-1:0]       array2,
    array_mac_streamer_if.master       out_if,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH+ROW+COL-1:0]   sum_out
);

    typedef enum logic [1:0] {IDLE, CAPTURE, RUN, FLUSH} state_t;

    state_t r_state;
    state_t w_nextState;

    logic [WIDTH-1:0]         r_snap1 [NUM];
    logic [WIDTH-1:0]         r_snap2 [NUM];
    logic [ROW-1:0]           r_i;
    logic [COL-1:0]           r_j;
    logic                     r_more;
    logic                     r_outValid;
    logic [WIDTH-1:0]         r_outData;
    logic [ROW-1:0]           r_outRow;
    logic [COL-1:0]           r_outCol;
    logic                     r_outLast;
    logic [WIDTH+ROW+COL-1:0] r_sum;

    logic [ROW+COL-1:0] w_idx1;
    logic [ROW+COL-1:0] w_idx2;
    logic [2*WIDTH-1:0] w_full;
    logic               w_xfer;
    logic               w_load;
    logic               w_lastIdx;

    // {i,j} is i*COL_SIZE+j for array1; {j,i} is j*ROW_SIZE+i for the transposed array2
    assign w_idx1    = {r_i, r_j};
    assign w_idx2    = {r_j, r_i};
    assign w_full    = {{WIDTH{1'b0}}, r_snap1[w_idx1]} * {{WIDTH{1'b0}}, r_snap2[w_idx2]};
    assign w_lastIdx = (&r_i) && (&r_j);

    // The output register refills whenever it is empty or being drained, giving one result per cycle
    assign w_xfer = r_outValid && out_if.out_ready;
    assign w_load = (r_state == RUN) && r_more && (!r_outValid || out_if.out_ready);

    assign out_if.out_valid = r_outValid;
    assign out_if.out_data  = r_outData;
    assign out_if.out_row   = r_outRow;
    assign out_if.out_col   = r_outCol;
    assign out_if.out_last  = r_outLast;
    assign sum_out          = r_sum;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus the busy flag and the one-cycle done pulse taken from FLUSH
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_nextState = CAPTURE;
                end
            end
            CAPTURE: begin
                w_nextState = RUN;
            end
            RUN: begin
                if (w_xfer && r_outLast) begin
                    w_nextState = FLUSH;
                end
            end
            FLUSH: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Input snapshots, taken once per pass; they carry no reset since nothing reads them before CAPTURE
    always_ff @(posedge clk) begin
        if (r_state == CAPTURE) begin
            for (int k = 0; k < NUM; k++) begin
                r_snap1[k] <= array1[k*WIDTH +: WIDTH];
                r_snap2[k] <= array2[k*WIDTH +: WIDTH];
            end
        end
    end

    // Index walk, registered product output and running total
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i        <= '0;
            r_j        <= '0;
            r_more     <= 1'b0;
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outRow   <= '0;
            r_outCol   <= '0;
            r_outLast  <= 1'b0;
            r_sum      <= '0;
        end else begin
            if (r_state == CAPTURE) begin
                r_i        <= '0;
                r_j        <= '0;
                r_more     <= 1'b1;
                r_outValid <= 1'b0;
                r_sum      <= '0;
            end
            if (r_state == RUN) begin
                if (w_xfer) begin
                    r_sum <= r_sum + {{(ROW+COL){1'b0}}, r_outData};
                end
                if (w_load) begin
                    r_outValid <= 1'b1;
                    r_outData  <= w_full[WIDTH-1:0];
                    r_outRow   <= r_i;
                    r_outCol   <= r_j;
                    r_outLast  <= w_lastIdx;
                    {r_i, r_j} <= {r_i, r_j} + 1'b1;
                    if (w_lastIdx) begin
                        r_more <= 1'b0;
                    end
                end else if (w_xfer) begin
                    r_outValid <= 1'b0;
                end
            end
        end
    end

endmodule
